// File: rtl/main_controller_pkg.sv
// Shared encodings for the multi-cycle RISC-V main controller: opcodes, FSM states,
// datapath select codes and the control output bundle.
package main_controller_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMMEXT    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // TRAP exists only when the illegal-opcode trap is built in.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LINK     = 4'd12,
        S_LUI      = 4'd13
`ifdef ILLEGAL_OP_TRAP_EN
        ,
        S_TRAP     = 4'd14
`endif
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic [1:0] alu_op;
        logic [2:0] imm_src;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/main_controller_branch_resolve.sv
// Branch condition from funct3 and the ALU zero flag (SLT/SLTU result for the ordered compares).
module branch_resolve
(
    input  logic [2:0] funct3,
    input  logic       zero,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000, 3'b101, 3'b111: taken = zero;
            3'b001, 3'b100, 3'b110: taken = ~zero;
            default:                taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/main_controller.sv
// Multi-cycle RISC-V (RV32I subset) main control FSM.
// Build option: ILLEGAL_OP_TRAP_EN adds an absorbing TRAP state for unsupported opcodes.
module main_controller
    import main_controller_pkg::*;
#(
    parameter int unsigned MEM_HANDSHAKE = 1
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       illegal_op
);

    state_e state;
    state_e state_next;
    ctrl_t  ctrl;
    logic   ready;
    logic   taken;

    assign ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    branch_resolve u_branch_resolve (
        .funct3 (funct3),
        .zero   (zero),
        .taken  (taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next state and control decode; reset forces every control low.
    always_comb begin
        ctrl       = '0;
        state_next = state;
        case (state)
            S_FETCH: begin
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURESULT;
                ctrl.ir_write   = ready;
                ctrl.pc_write   = ready;
                if (ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.imm_src   = (op == OP_BRANCH) ? IMM_B :
                                 (op == OP_JAL)    ? IMM_J : IMM_I;
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI:            state_next = S_LUI;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:           state_next = S_TRAP;
`else
                    default:           state_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.imm_src   = (op == OP_LOAD) ? IMM_I : IMM_S;
                state_next     = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                ctrl.adr_src = 1'b1;
                if (ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
                state_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                if (ready) state_next = S_FETCH;
            end
            S_EXECR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_RTYPE;
                state_next     = S_ALUWB;
            end
            S_EXECI: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.imm_src   = IMM_I;
                ctrl.alu_op    = ALUOP_ITYPE;
                state_next     = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
                state_next      = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALUOP_BRANCH;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = taken;
                state_next      = S_FETCH;
            end
            S_JAL: begin
                // Target was formed in DECODE; ALU now builds the link value OldPC+4.
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = 1'b1;
                state_next      = S_ALUWB;
            end
            S_JALR: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.imm_src    = IMM_I;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURESULT;
                ctrl.pc_write   = 1'b1;
                state_next      = S_LINK;
            end
            S_LINK: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURESULT;
                ctrl.reg_write  = 1'b1;
                state_next      = S_FETCH;
            end
            S_LUI: begin
                ctrl.imm_src    = IMM_U;
                ctrl.result_src = RES_IMMEXT;
                ctrl.reg_write  = 1'b1;
                state_next      = S_FETCH;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            S_TRAP: begin
                ctrl.illegal_op = 1'b1;
                state_next      = S_TRAP;
            end
`endif
            default: begin
                state_next = S_FETCH;
            end
        endcase
        if (rst) ctrl = '0;
    end

    assign pc_write   = ctrl.pc_write;
    assign adr_src    = ctrl.adr_src;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign result_src = ctrl.result_src;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign reg_write  = ctrl.reg_write;
    assign alu_op     = ctrl.alu_op;
    assign imm_src    = ctrl.imm_src;
    assign illegal_op = ctrl.illegal_op;

endmodule

// File: tb/tb_main_controller.sv
// Directed, table-driven bench for main_controller: one vector per clock cycle, plus a CPI check.
module tb_main_controller;

    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_RTYPE  = 7'b0110011;
    localparam logic [6:0] T_ITYPE  = 7'b0010011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam logic [6:0] T_LUI    = 7'b0110111;
    localparam logic [6:0] T_BAD    = 7'b0000000;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0] imm_src;

    main_controller dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct3     (funct3),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .reg_write  (reg_write),
        .alu_op     (alu_op),
        .imm_src    (imm_src),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        zero;
        logic        mr;
        logic [17:0] exp;
        logic [63:0] name;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Bundle order: pcw adr mw irw rs[2] srca[2] srcb[2] rw aluop[2] imm[3] ill
    function automatic logic [17:0] bundle(input logic pcw, input logic adr, input logic mw,
                                           input logic irw, input logic [1:0] rs,
                                           input logic [1:0] sa, input logic [1:0] sb,
                                           input logic rw, input logic [1:0] aop,
                                           input logic [2:0] imm, input logic ill);
        return {pcw, adr, mw, irw, rs, sa, sb, rw, aop, imm, ill};
    endfunction

    function automatic logic [17:0] e_fetch(input logic mr);
        return bundle(mr, 1'b0, 1'b0, mr, 2'b10, 2'b00, 2'b10, 1'b0, 2'b00, 3'b000, 1'b0);
    endfunction
    function automatic logic [17:0] e_decode(input logic [2:0] imm);
        return bundle(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0, 2'b00, imm, 1'b0);
    endfunction
    function automatic logic [17:0] e_memadr(input logic [2:0] imm);
        return bundle(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, 2'b00, imm, 1'b0);
    endfunction
    function automatic logic [17:0] e_branch(input logic t);
        return bundle(t, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 2'b01, 3'b000, 1'b0);
    endfunction

    logic [17:0] E_ZERO, E_MEMREAD, E_MEMWB, E_MEMWRITE, E_EXECR, E_EXECI, E_ALUWB;
    logic [17:0] E_JAL, E_JALR, E_LINK, E_LUI, E_TRAP;

    task automatic add(input logic r, input logic [6:0] o, input logic [2:0] f,
                       input logic z, input logic mr, input logic [17:0] e,
                       input logic [63:0] nm);
        vec_t v;
        v.rst = r; v.op = o; v.f3 = f; v.zero = z; v.mr = mr; v.exp = e; v.name = nm;
        vecs.push_back(v);
    endtask

    function automatic logic [17:0] actual();
        return {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
                reg_write, alu_op, imm_src, illegal_op};
    endfunction

    task automatic branch_case(input logic [2:0] f, input logic z, input logic t);
        add(0, T_BRANCH, f, 0, 1, e_fetch(1), "br_fet");
        add(0, T_BRANCH, f, 0, 1, e_decode(3'b010), "br_dec");
        add(0, T_BRANCH, f, z, 1, e_branch(t), "br_res");
    endtask

    initial begin
        int cyc;
        int rw_seen;
        logic done;

        E_ZERO     = '0;
        E_MEMREAD  = bundle(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0);
        E_MEMWB    = bundle(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 2'b00, 3'b000, 0);
        E_MEMWRITE = bundle(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 3'b000, 0);
        E_EXECR    = bundle(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b10, 3'b000, 0);
        E_EXECI    = bundle(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b11, 3'b000, 0);
        E_ALUWB    = bundle(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 3'b000, 0);
        E_JAL      = bundle(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 2'b00, 3'b000, 0);
        E_JALR     = bundle(1, 0, 0, 0, 2'b10, 2'b10, 2'b01, 0, 2'b00, 3'b000, 0);
        E_LINK     = bundle(0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 1, 2'b00, 3'b000, 0);
        E_LUI      = bundle(0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 1, 2'b00, 3'b100, 0);
        E_TRAP     = bundle(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 3'b000, 1);

        add(1, T_RTYPE, 3'b000, 0, 1, E_ZERO, "reset0");
        add(1, T_RTYPE, 3'b000, 0, 1, E_ZERO, "reset1");
        // R-type add
        add(0, T_RTYPE, 3'b000, 0, 1, e_fetch(1), "add_fet");
        add(0, T_RTYPE, 3'b000, 0, 1, e_decode(3'b000), "add_dec");
        add(0, T_RTYPE, 3'b000, 0, 1, E_EXECR, "add_exe");
        add(0, T_RTYPE, 3'b000, 0, 1, E_ALUWB, "add_wb");
        // I-type addi
        add(0, T_ITYPE, 3'b000, 0, 1, e_fetch(1), "addi_fet");
        add(0, T_ITYPE, 3'b000, 0, 1, e_decode(3'b000), "addi_dec");
        add(0, T_ITYPE, 3'b000, 0, 1, E_EXECI, "addi_exe");
        add(0, T_ITYPE, 3'b000, 0, 1, E_ALUWB, "addi_wb");
        // lw with one fetch stall and three read stalls
        add(0, T_LOAD, 3'b010, 0, 0, e_fetch(0), "lw_fwait");
        add(0, T_LOAD, 3'b010, 0, 1, e_fetch(1), "lw_fet");
        add(0, T_LOAD, 3'b010, 0, 1, e_decode(3'b000), "lw_dec");
        add(0, T_LOAD, 3'b010, 0, 1, e_memadr(3'b000), "lw_adr");
        add(0, T_LOAD, 3'b010, 0, 0, E_MEMREAD, "lw_rd0");
        add(0, T_LOAD, 3'b010, 0, 0, E_MEMREAD, "lw_rd1");
        add(0, T_LOAD, 3'b010, 0, 0, E_MEMREAD, "lw_rd2");
        add(0, T_LOAD, 3'b010, 0, 1, E_MEMREAD, "lw_rd3");
        add(0, T_LOAD, 3'b010, 0, 1, E_MEMWB, "lw_wb");
        // sw with two write stalls
        add(0, T_STORE, 3'b010, 0, 1, e_fetch(1), "sw_fet");
        add(0, T_STORE, 3'b010, 0, 1, e_decode(3'b000), "sw_dec");
        add(0, T_STORE, 3'b010, 0, 1, e_memadr(3'b001), "sw_adr");
        add(0, T_STORE, 3'b010, 0, 0, E_MEMWRITE, "sw_wr0");
        add(0, T_STORE, 3'b010, 0, 0, E_MEMWRITE, "sw_wr1");
        add(0, T_STORE, 3'b010, 0, 1, E_MEMWRITE, "sw_wr2");
        // branch resolution across funct3 / zero
        branch_case(3'b000, 1, 1);
        branch_case(3'b000, 0, 0);
        branch_case(3'b001, 1, 0);
        branch_case(3'b101, 0, 0);
        branch_case(3'b100, 0, 1);
        branch_case(3'b110, 1, 0);
        branch_case(3'b111, 1, 1);
        branch_case(3'b010, 1, 0);
        branch_case(3'b011, 0, 0);
        // jal
        add(0, T_JAL, 3'b000, 0, 1, e_fetch(1), "jal_fet");
        add(0, T_JAL, 3'b000, 0, 1, e_decode(3'b011), "jal_dec");
        add(0, T_JAL, 3'b000, 0, 1, E_JAL, "jal_exe");
        add(0, T_JAL, 3'b000, 0, 1, E_ALUWB, "jal_wb");
        // jalr
        add(0, T_JALR, 3'b000, 0, 1, e_fetch(1), "jalr_fet");
        add(0, T_JALR, 3'b000, 0, 1, e_decode(3'b000), "jalr_dec");
        add(0, T_JALR, 3'b000, 0, 1, E_JALR, "jalr_exe");
        add(0, T_JALR, 3'b000, 0, 1, E_LINK, "jalr_lnk");
        // reset abandons a pending store
        add(0, T_STORE, 3'b010, 0, 1, e_fetch(1), "swr_fet");
        add(0, T_STORE, 3'b010, 0, 1, e_decode(3'b000), "swr_dec");
        add(0, T_STORE, 3'b010, 0, 1, e_memadr(3'b001), "swr_adr");
        add(0, T_STORE, 3'b010, 0, 0, E_MEMWRITE, "swr_wr");
        add(1, T_STORE, 3'b010, 0, 0, E_ZERO, "swr_rst");
        add(0, T_STORE, 3'b010, 0, 1, e_fetch(1), "swr_fet2");
        add(0, T_STORE, 3'b010, 0, 1, e_decode(3'b000), "swr_dec2");
        add(0, T_STORE, 3'b010, 0, 1, e_memadr(3'b001), "swr_adr2");
        add(0, T_STORE, 3'b010, 0, 1, E_MEMWRITE, "swr_wr2");
        // unsupported opcode
        add(0, T_BAD, 3'b000, 0, 1, e_fetch(1), "bad_fet");
        add(0, T_BAD, 3'b000, 0, 1, e_decode(3'b000), "bad_dec");
`ifdef ILLEGAL_OP_TRAP_EN
        add(0, T_BAD, 3'b000, 0, 1, E_TRAP, "trap0");
        add(0, T_RTYPE, 3'b000, 0, 1, E_TRAP, "trap1");
        add(0, T_RTYPE, 3'b000, 0, 1, E_TRAP, "trap2");
        add(1, T_RTYPE, 3'b000, 0, 1, E_ZERO, "trap_rst");
`endif
        // lui, also checks return to FETCH with illegal_op low
        add(0, T_LUI, 3'b000, 0, 1, e_fetch(1), "lui_fet");
        add(0, T_LUI, 3'b000, 0, 1, e_decode(3'b000), "lui_dec");
        add(0, T_LUI, 3'b000, 0, 1, E_LUI, "lui_exe");

        rst = 1'b1; op = T_RTYPE; funct3 = 3'b000; zero = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; op = vecs[i].op; funct3 = vecs[i].f3;
            zero = vecs[i].zero; mem_ready = vecs[i].mr;
            @(negedge clk);
            n_vec++;
            if (actual() !== vecs[i].exp) begin
                n_bad++;
                $display("FAIL vec %0d %0s: got %b required %b", i, vecs[i].name,
                         actual(), vecs[i].exp);
            end
            @(posedge clk); #1;
        end

        // Cycle count of an add from one fetch to the next, bounded
        rst = 1'b0; op = T_RTYPE; funct3 = 3'b000; zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ir_write !== 1'b1) begin
            n_bad++;
            $display("FAIL cpi_start: ir_write got %b required 1", ir_write);
        end
        cyc = 0; rw_seen = 0; done = 1'b0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (reg_write === 1'b1) rw_seen++;
            if (ir_write === 1'b1) done = 1'b1;
        end
        n_vec++;
        if (!done || cyc != 4) begin
            n_bad++;
            $display("FAIL cpi_add: cycles got %0d required 4 (done=%0b)", cyc, done);
        end
        n_vec++;
        if (rw_seen != 1) begin
            n_bad++;
            $display("FAIL cpi_regwrite: pulses got %0d required 1", rw_seen);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
